// File: rtl/dma_reg_pkg.sv
// Shared definitions for the DMA register block: register offsets,
// control/status bit positions and the copy engine state encoding.
package dma_reg_pkg;

  localparam logic [4:0] CTRL_OFF     = 5'h00;
  localparam logic [4:0] STATUS_OFF   = 5'h04;
  localparam logic [4:0] SRC_ADDR_OFF = 5'h08;
  localparam logic [4:0] DST_ADDR_OFF = 5'h0C;
  localparam logic [4:0] LENGTH_OFF   = 5'h10;
  localparam logic [4:0] INTR_CLR_OFF = 5'h14;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_INTR_EN_BIT = 1;
  localparam int CTRL_ABORT_BIT   = 2;

  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;
  localparam int STAT_REMAIN_LSB = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_copy_fsm.sv
// Word-by-word memory-to-memory copy engine. Owns the working source,
// destination and remaining count, the DONE/ERR/BUSY flags and the
// req/ack memory port. All memory port outputs are registered.
module dma_copy_fsm
  import dma_reg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_done,
  input  logic              clr_err,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  remaining,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  dma_state_e        state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic              abort_pend;
  logic              abort_now;
  logic [ADDR_W-1:0] src_next;

  // An abort arriving in the same cycle as the ack counts just like one
  // that arrived earlier and was held pending.
  assign abort_now = abort | abort_pend;
  assign src_next  = src + ADDR_W'(4);

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Copy sequencer: flag clears are applied first so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      remaining  <= '0;
      src        <= '0;
      dst        <= '0;
      abort_pend <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (clr_done) done <= 1'b0;
      if (clr_err)  err  <= 1'b0;
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start) begin
            if (len_in == '0) begin
              err <= 1'b1;
            end else begin
              state     <= RD;
              busy      <= 1'b1;
              done      <= 1'b0;
              err       <= 1'b0;
              src       <= src_in;
              dst       <= dst_in;
              remaining <= len_in;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= word_addr(src_in);
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            mem_wdata <= mem_rdata;
            if (abort_now) begin
              state      <= IDLE;
              busy       <= 1'b0;
              err        <= 1'b1;
              mem_req    <= 1'b0;
              abort_pend <= 1'b0;
            end else begin
              state    <= WR;
              mem_we   <= 1'b1;
              mem_addr <= word_addr(dst);
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        WR: begin
          if (mem_ack) begin
            src       <= src_next;
            dst       <= dst + ADDR_W'(4);
            remaining <= remaining - LEN_W'(1);
            mem_we    <= 1'b0;
            if (abort_now) begin
              state      <= IDLE;
              busy       <= 1'b0;
              err        <= 1'b1;
              mem_req    <= 1'b0;
              abort_pend <= 1'b0;
            end else if (remaining == LEN_W'(1)) begin
              state   <= FIN;
              mem_req <= 1'b0;
            end else begin
              state    <= RD;
              mem_addr <= word_addr(src_next);
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dma_reg_ctrl.sv
// DMA register block: decodes the register bus into CTRL/STATUS/SRC/DST/
// LENGTH/INTR_CLR, drives the copy engine and produces the level interrupt.
// The reset input is synchronous and active-high despite its name.
module dma_reg_ctrl
  import dma_reg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              irq
);

  logic [4:0]        reg_off;
  logic              intr_en;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  remaining;
  logic              start_p;
  logic              abort_p;
  logic              clr_done;
  logic              clr_err;
  logic [DATA_W-1:0] rd_val;
  logic              unused_addr_bits;

  assign reg_off          = {addr[4:2], 2'b00};
  assign unused_addr_bits = ^{addr[ADDR_W-1:5], addr[1:0]};

  assign start_p  = wr_en && (reg_off == CTRL_OFF) && wdata[CTRL_START_BIT];
  assign abort_p  = wr_en && (reg_off == CTRL_OFF) && wdata[CTRL_ABORT_BIT];
  assign clr_done = wr_en && (reg_off == INTR_CLR_OFF) && wdata[STAT_DONE_BIT];
  assign clr_err  = wr_en && (reg_off == INTR_CLR_OFF) && wdata[STAT_ERR_BIT];

  // Register writes; transfer parameters are frozen while a copy is running.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      intr_en <= 1'b0;
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
    end else if (wr_en) begin
      case (reg_off)
        CTRL_OFF:     intr_en <= wdata[CTRL_INTR_EN_BIT];
        SRC_ADDR_OFF: if (!busy) src_reg <= ADDR_W'(wdata);
        DST_ADDR_OFF: if (!busy) dst_reg <= ADDR_W'(wdata);
        LENGTH_OFF:   if (!busy) len_reg <= wdata[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rd_val = '0;
    case (reg_off)
      CTRL_OFF: rd_val[CTRL_INTR_EN_BIT] = intr_en;
      STATUS_OFF: begin
        rd_val[STAT_BUSY_BIT]                = busy;
        rd_val[STAT_DONE_BIT]                = done;
        rd_val[STAT_ERR_BIT]                 = err;
        rd_val[STAT_REMAIN_LSB +: LEN_W]     = remaining;
      end
      SRC_ADDR_OFF: rd_val = DATA_W'(src_reg);
      DST_ADDR_OFF: rd_val = DATA_W'(dst_reg);
      LENGTH_OFF:   rd_val = DATA_W'(len_reg);
      default: ;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk) begin
    if (rst_n)      rdata <= '0;
    else if (rd_en) rdata <= rd_val;
  end

  // Level interrupt, one cycle behind DONE.
  always_ff @(posedge clk) begin
    if (rst_n) irq <= 1'b0;
    else       irq <= done & intr_en;
  end

  dma_copy_fsm #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) u_copy_fsm (
    .clk      (clk),
    .rst      (rst_n),
    .start    (start_p),
    .abort    (abort_p),
    .clr_done (clr_done),
    .clr_err  (clr_err),
    .src_in   (src_reg),
    .dst_in   (dst_reg),
    .len_in   (len_reg),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .remaining(remaining),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

endmodule

// File: tb/tb_dma_reg_ctrl.sv
// Testbench for dma_reg_ctrl: directed register/copy scenarios with a
// scoreboard for register reads and memory transactions.
module tb_dma_reg_ctrl;

  localparam logic [31:0] PAT = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  rd_exp_t  rd_q[$];
  mem_exp_t mem_q[$];

  int   n_tests   = 0;
  int   n_fail    = 0;
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  int   ack_count = 0;
  logic rd_issued = 1'b0;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the word address.
  assign mem_rdata = mem_addr ^ PAT;

  dma_reg_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .LEN_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .irq      (irq)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Remember which posedges carried a read so rdata is checked one cycle later.
  always @(posedge clk) rd_issued <= rd_en;

  // Register read monitor.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_issued) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read", rdata);
      end else begin
        e = rd_q.pop_front();
        check_output(e.name, rdata, e.val);
      end
    end
  end

  // Memory model with configurable ack delay, plus transaction monitor.
  always @(negedge clk) begin
    mem_exp_t e;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        ack_count++;
        if (mem_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_mem_txn: got we=%0b addr=0x%08h, expected none", mem_we, mem_addr);
        end else begin
          e = mem_q.pop_front();
          check_output("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          check_output("mem_addr", mem_addr, e.addr);
          if (e.we) check_output("mem_wdata", mem_wdata, e.data);
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_exp_t e;
    e.we   = we;
    e.addr = a;
    e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, input string name, input logic [31:0] exp);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    rd_q.push_back(e);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic write_read_reg(input logic [31:0] a, input logic [31:0] d,
                                input string name, input logic [31:0] exp);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    rd_q.push_back(e);
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wait_acks(input int target, input string name);
    int cyc = 0;
    while (ack_count < target && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    check_output(name, 32'(ack_count), 32'(target));
    @(negedge clk);
  endtask

  task automatic apply_stimulus();
    // Reset readback
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("reset_mem_req", {31'b0, mem_req}, 32'h0);
    check_output("reset_irq", {31'b0, irq}, 32'h0);
    read_reg(32'h00, "reset_ctrl", 32'h0);
    read_reg(32'h04, "reset_status", 32'h0);
    read_reg(32'h08, "reset_src", 32'h0);
    read_reg(32'h0C, "reset_dst", 32'h0);
    read_reg(32'h10, "reset_length", 32'h0);
    read_reg(32'h14, "reset_intr_clr", 32'h0);
    read_reg(32'h18, "unmapped_read", 32'h0);

    // Write and read in the same cycle returns the old value
    write_read_reg(32'h08, 32'h1111_2220, "wr_rd_old_src", 32'h0);
    read_reg(32'h0B, "src_after_wr", 32'h1111_2220);

    // Normal copy, immediate ack
    ack_delay = 0;
    push_mem(1'b0, 32'h1000, 32'h0);
    push_mem(1'b1, 32'h2000, 32'h1000 ^ PAT);
    push_mem(1'b0, 32'h1004, 32'h0);
    push_mem(1'b1, 32'h2004, 32'h1004 ^ PAT);
    push_mem(1'b0, 32'h1008, 32'h0);
    push_mem(1'b1, 32'h2008, 32'h1008 ^ PAT);
    write_reg(32'h08, 32'h1000);
    write_reg(32'h0C, 32'h2000);
    write_reg(32'h10, 32'hFFFF_0003);
    read_reg(32'h10, "length_upper_zero", 32'h3);
    ack_count = 0;
    write_reg(32'h00, 32'h3);
    wait_acks(6, "copy_acks");
    repeat (3) @(negedge clk);
    check_output("copy_irq_set", {31'b0, irq}, 32'h1);
    read_reg(32'h04, "copy_status", 32'h2);
    read_reg(32'h00, "ctrl_readback", 32'h2);
    write_reg(32'h14, 32'h2);
    @(negedge clk);
    check_output("irq_cleared", {31'b0, irq}, 32'h0);
    read_reg(32'h04, "status_after_clr", 32'h0);

    // Zero length start
    write_reg(32'h10, 32'h0);
    ack_count = 0;
    write_reg(32'h00, 32'h1);
    repeat (3) @(negedge clk);
    check_output("zero_len_no_req", {31'b0, mem_req}, 32'h0);
    check_output("zero_len_no_acks", 32'(ack_count), 32'h0);
    read_reg(32'h04, "zero_len_status", 32'h4);

    // Busy protection and START while busy
    ack_delay = 5;
    push_mem(1'b0, 32'h3000, 32'h0);
    push_mem(1'b1, 32'h4000, 32'h3000 ^ PAT);
    push_mem(1'b0, 32'h3004, 32'h0);
    push_mem(1'b1, 32'h4004, 32'h3004 ^ PAT);
    write_reg(32'h08, 32'h3000);
    write_reg(32'h0C, 32'h4000);
    write_reg(32'h10, 32'h2);
    ack_count = 0;
    write_reg(32'h00, 32'h1);
    write_reg(32'h08, 32'hDEAD_0000);
    write_reg(32'h00, 32'h1);
    read_reg(32'h08, "src_busy_protect", 32'h3000);
    read_reg(32'h04, "status_busy", 32'h0002_0001);
    wait_acks(4, "busy_acks");
    repeat (3) @(negedge clk);
    read_reg(32'h04, "busy_test_status", 32'h2);

    // Abort during the second read
    ack_delay = 3;
    push_mem(1'b0, 32'h6000, 32'h0);
    push_mem(1'b1, 32'h7000, 32'h6000 ^ PAT);
    push_mem(1'b0, 32'h6004, 32'h0);
    write_reg(32'h08, 32'h6000);
    write_reg(32'h0C, 32'h7000);
    write_reg(32'h10, 32'h4);
    ack_count = 0;
    write_reg(32'h00, 32'h1);
    wait_acks(2, "abort_first_word");
    write_reg(32'h00, 32'h4);
    wait_acks(3, "abort_read_done");
    repeat (6) @(negedge clk);
    check_output("abort_no_req", {31'b0, mem_req}, 32'h0);
    read_reg(32'h04, "abort_status", 32'h0003_0004);

    // Source address wrap
    ack_delay = 0;
    push_mem(1'b0, 32'hFFFF_FFFC, 32'h0);
    push_mem(1'b1, 32'h5000, 32'hFFFF_FFFC ^ PAT);
    push_mem(1'b0, 32'h0000_0000, 32'h0);
    push_mem(1'b1, 32'h5004, 32'h0000_0000 ^ PAT);
    write_reg(32'h08, 32'hFFFF_FFFC);
    write_reg(32'h0C, 32'h5000);
    write_reg(32'h10, 32'h2);
    ack_count = 0;
    write_reg(32'h00, 32'h1);
    wait_acks(4, "wrap_acks");
    repeat (3) @(negedge clk);
    read_reg(32'h04, "wrap_status", 32'h2);
    read_reg(32'h08, "wrap_src_reg", 32'hFFFF_FFFC);
    check_output("irq_masked", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wdata   = '0;
    mem_ack = 1'b0;
    apply_stimulus();
    check_output("mem_q_drained", 32'(mem_q.size()), 32'h0);
    check_output("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
